ise_image_feeder: RTL and testbench
===================================

Name: ise_image_feeder

Overview:
- Upstream driver for the image sorting engine.
- Reads NUM_IMAGES images of PIX_PER_IMAGE 24-bit RGB pixels from a synchronous pixel ROM and streams them to the engine's pixel_in/image_in_index, throttled by the engine's busy.
- Collects the engine's sorted output stream (out_valid, color_index, image_out_index) into a result buffer and checks the stream.
- Acts as the transmit/collect end of the engine interface, used in the system and as a self-checking stimulus block.

Parameters:
NUM_IMAGES, 32, images per run (power of 2)
PIX_PER_IMAGE, 16384, pixels per image (power of 2)
ADDR_W, 19, ROM address width = log2(NUM_IMAGES*PIX_PER_IMAGE)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a run when idle
rom_addr  out  ADDR_W  pixel ROM address = image*PIX_PER_IMAGE + pixel
rom_rd  out  1  ROM read enable; rom_rdata valid exactly 1 cycle later
rom_rdata  in  24  ROM read data {R,G,B}
busy  in  1  engine busy; pixel consumed on each edge with busy=0 and pix_valid=1
pix_valid  out  1  pixel_in/image_in_index hold a valid pixel
pixel_in  out  24  current pixel
image_in_index  out  5  index of image being sent
out_valid  in  1  engine result strobe
color_index  in  2  result color class (0=R, 1=G, 2=B)
image_out_index  in  5  result image index
res_rd_addr  in  5  result buffer read address
res_rd_data  out  7  {color_index, image_out_index} at res_rd_addr, registered, 1-cycle latency
run_busy  out  1  run in progress
done  out  1  high from run completion until next start
error  out  1  sticky stream error; cleared by start

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- States:
  - IDLE: wait for start.
  - STREAM: stream pixels.
  - COLLECT: wait for NUM_IMAGES results.
  - DONE: done=1; start returns to STREAM.
  - run_busy=1 in STREAM and COLLECT.
- start while not IDLE/DONE: ignored.
- start in IDLE/DONE clears error, result count and pixel/image counters. Next state is STREAM.
- Read pipeline: 2-entry skid buffer between ROM and output register.
  - rom_rd asserted only when the buffer holds fewer than 2 entries after accounting for reads in flight, so no ROM data is ever dropped.
  - First pixel_in visible 2 cycles after start.
  - Afterwards pix_valid stays high continuously while busy=0 (one pixel per cycle).
- While busy=1: pixel_in, image_in_index and pix_valid hold stable.
- Output on each consume:
  - pixel counter increments.
  - At PIX_PER_IMAGE-1 it wraps to 0 and image_in_index increments.
  - image_in_index never changes mid-image.
- After the last pixel of image NUM_IMAGES-1 is consumed:
  - pix_valid drops in that same edge's update; no further rom_rd.
  - state goes to COLLECT.
- Results are accepted in STREAM and COLLECT. Each out_valid=1 edge:
  - writes {color_index, image_out_index} to buffer[result_count].
  - increments result_count (6 bits).
- Results are written in arrival order. When result_count reaches NUM_IMAGES, state goes to DONE on the next edge.
- error set (sticky) on any of:
  - color_index==3 with out_valid.
  - color_index lower than the previous result's color_index (engine orders R, then G, then B).
  - out_valid while result_count==NUM_IMAGES or while IDLE/DONE; the result is not written.
- Simultaneous last-pixel consume and out_valid: both take effect.
- Reset mid-run: everything returns to reset values at once, including clearing the skid buffer. ROM data returning after reset is ignored.
- res_rd_data is readable in any state; entries are undefined before being written.

Test Plan:
- Reset, start pulse, busy=0 always, ROM data = address -> image 0 pixels 0..16383 on consecutive cycles from cycle 2. image_in_index increments to 1 exactly after pixel 16383 is consumed.
- busy toggled 1-cycle high every 3rd cycle, and a 40-cycle busy=1 gap between images -> no pixel lost or duplicated. Output sequence equals ROM addresses 0..524287 in order. Outputs stable while busy=1.
- 32 out_valid strobes, colors 0,0,1,2... with index values 31..0 -> done=1, error=0. res_rd_addr=5 returns the 6th pair one cycle later.
- Result sequence color 2 then color 0 -> error=1 and stays 1 until next start.
- color_index=3, or a 33rd out_valid -> error=1. The 33rd result is not stored.
- reset driven low mid-image 7 for 1 cycle -> all outputs 0 immediately. Next start restarts from image 0 pixel 0.

Source files
------------

// File: rtl/ise_image_feeder.sv
// ise_image_feeder: streams NUM_IMAGES images of RGB pixels from a synchronous
// pixel ROM into the image sorting engine and collects/checks its result stream.
// A two-entry skid buffer sits between the ROM read port and the pixel output
// register, so the ROM can be read ahead without ever dropping data under busy.
module ise_image_feeder #(
  parameter int NUM_IMAGES    = 32,
  parameter int PIX_PER_IMAGE = 16384,
  parameter int ADDR_W        = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [23:0]       rom_rdata,
  input  logic              busy,
  output logic              pix_valid,
  output logic [23:0]       pixel_in,
  output logic [4:0]        image_in_index,
  input  logic              out_valid,
  input  logic [1:0]        color_index,
  input  logic [4:0]        image_out_index,
  input  logic [4:0]        res_rd_addr,
  output logic [6:0]        res_rd_data,
  output logic              run_busy,
  output logic              done,
  output logic              error
);

  localparam int PIX_W = (PIX_PER_IMAGE > 1) ? $clog2(PIX_PER_IMAGE) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(NUM_IMAGES * PIX_PER_IMAGE);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIX_PER_IMAGE - 1);
  localparam logic [4:0]       LAST_IMG = 5'(NUM_IMAGES - 1);
  localparam logic [5:0]       RES_FULL = 6'(NUM_IMAGES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STREAM  = 2'd1,
    S_COLLECT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Read side: issued-read counter and the read whose data returns next cycle
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             inflight_q, inflight_d;

  // Skid buffer: fifo0 is the head entry
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [23:0] fifo0_q, fifo0_d;
  logic [23:0] fifo1_q, fifo1_d;

  // Pixel output register and position of the presented pixel
  logic             pv_q, pv_d;
  logic [23:0]      pix_q, pix_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [4:0]       img_q, img_d;

  // Result collection
  logic [5:0] res_cnt_q, res_cnt_d;
  logic [1:0] last_col_q, last_col_d;
  logic       err_q, err_d;
  logic       res_wr;
  logic [6:0] res_rd_q;
  logic [6:0] res_mem [0:31];

  logic start_run;
  logic consume;
  logic last_consume;
  logic active;
  logic slot_free;
  logic pop;
  logic push;
  logic [2:0] occupancy;

  assign start_run    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign consume      = pv_q && !busy;
  assign last_consume = consume && (pix_cnt_q == LAST_PIX) && (img_q == LAST_IMG);
  assign active       = (state_q == S_STREAM) || (state_q == S_COLLECT);
  assign occupancy    = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};

  assign rom_addr       = rd_cnt_q[ADDR_W-1:0];
  assign pix_valid      = pv_q;
  assign pixel_in       = pix_q;
  assign image_in_index = img_q;
  assign res_rd_data    = res_rd_q;
  assign error          = err_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_STREAM;
      S_STREAM:  if (last_consume) state_d = S_COLLECT;
      S_COLLECT: if (res_cnt_q == RES_FULL) state_d = S_DONE;
      S_DONE:    if (start) state_d = S_STREAM;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs; ROM reads only while the buffer can absorb everything in flight
  always_comb begin
    run_busy = (state_q == S_STREAM) || (state_q == S_COLLECT);
    done     = (state_q == S_DONE);
    rom_rd   = (state_q == S_STREAM) && (rd_cnt_q != TOTAL) && (occupancy < 3'd2);
  end

  // Pixel datapath: refill the output register from the skid head, else straight from ROM
  always_comb begin
    rd_cnt_d   = rd_cnt_q;
    inflight_d = rom_rd;
    fifo_cnt_d = fifo_cnt_q;
    fifo0_d    = fifo0_q;
    fifo1_d    = fifo1_q;
    pv_d       = pv_q;
    pix_d      = pix_q;
    pix_cnt_d  = pix_cnt_q;
    img_d      = img_q;
    slot_free  = 1'b0;
    pop        = 1'b0;
    push       = 1'b0;
    if (start_run) begin
      rd_cnt_d   = '0;
      inflight_d = 1'b0;
      fifo_cnt_d = 2'd0;
      pv_d       = 1'b0;
      pix_cnt_d  = '0;
      img_d      = 5'd0;
    end else if (state_q == S_STREAM) begin
      if (rom_rd) rd_cnt_d = rd_cnt_q + CNT_W'(1);
      push      = inflight_q;
      slot_free = !pv_q || consume;
      if (consume) begin
        if (pix_cnt_q == LAST_PIX) begin
          pix_cnt_d = '0;
          // Hold the index on the final pixel so it never points past the run
          if (img_q != LAST_IMG) img_d = img_q + 5'd1;
        end else begin
          pix_cnt_d = pix_cnt_q + PIX_W'(1);
        end
      end
      if (last_consume) begin
        pv_d = 1'b0;
      end else if (slot_free) begin
        if (fifo_cnt_q != 2'd0) begin
          pix_d = fifo0_q;
          pv_d  = 1'b1;
          pop   = 1'b1;
        end else if (inflight_q) begin
          pix_d = rom_rdata;
          pv_d  = 1'b1;
          push  = 1'b0;
        end else begin
          pv_d  = 1'b0;
        end
      end
      unique case ({pop, push})
        2'b10: begin
          fifo0_d    = fifo1_q;
          fifo_cnt_d = fifo_cnt_q - 2'd1;
        end
        2'b01: begin
          if (fifo_cnt_q == 2'd0) fifo0_d = rom_rdata;
          else                    fifo1_d = rom_rdata;
          fifo_cnt_d = fifo_cnt_q + 2'd1;
        end
        2'b11: begin
          if (fifo_cnt_q == 2'd1) begin
            fifo0_d = rom_rdata;
          end else begin
            fifo0_d = fifo1_q;
            fifo1_d = rom_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Result stream: store in arrival order and flag ordering/overflow/class errors
  always_comb begin
    res_cnt_d  = res_cnt_q;
    last_col_d = last_col_q;
    err_d      = err_q;
    res_wr     = 1'b0;
    if (start_run) begin
      res_cnt_d  = 6'd0;
      last_col_d = 2'd0;
      err_d      = 1'b0;
    end
    if (out_valid) begin
      if (active && (res_cnt_q != RES_FULL)) begin
        res_wr     = 1'b1;
        res_cnt_d  = res_cnt_q + 6'd1;
        last_col_d = color_index;
        if ((color_index == 2'd3) || (color_index < last_col_q)) err_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt_q   <= '0;
      inflight_q <= 1'b0;
      fifo_cnt_q <= 2'd0;
      pv_q       <= 1'b0;
      pix_q      <= 24'd0;
      pix_cnt_q  <= '0;
      img_q      <= 5'd0;
      res_cnt_q  <= 6'd0;
      last_col_q <= 2'd0;
      err_q      <= 1'b0;
      res_rd_q   <= 7'd0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      pv_q       <= pv_d;
      pix_q      <= pix_d;
      pix_cnt_q  <= pix_cnt_d;
      img_q      <= img_d;
      res_cnt_q  <= res_cnt_d;
      last_col_q <= last_col_d;
      err_q      <= err_d;
      res_rd_q   <= res_mem[res_rd_addr];
    end
  end

  // Skid buffer payload and result memory carry no reset; occupancy/count gate their use
  always_ff @(posedge clk) begin
    fifo0_q <= fifo0_d;
    fifo1_q <= fifo1_d;
    if (res_wr) res_mem[res_cnt_q[4:0]] <= {color_index, image_out_index};
  end

endmodule

// File: tb/tb_ise_image_feeder.sv
// Directed bench for ise_image_feeder with a reduced image size and an
// address-echo ROM (data = address).
module tb_ise_image_feeder;

  localparam int NIMG   = 32;
  localparam int PPI    = 16;
  localparam int AW     = 9;
  localparam int TOTAL  = NIMG * PPI;
  localparam int BUDGET = 5000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] rom_addr;
  logic          rom_rd;
  logic [23:0]   rom_rdata = 24'd0;
  logic          busy;
  logic          pix_valid;
  logic [23:0]   pixel_in;
  logic [4:0]    image_in_index;
  logic          out_valid;
  logic [1:0]    color_index;
  logic [4:0]    image_out_index;
  logic [4:0]    res_rd_addr;
  logic [6:0]    res_rd_data;
  logic          run_busy;
  logic          done;
  logic          error;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_pix  = 0;

  ise_image_feeder #(
    .NUM_IMAGES   (NIMG),
    .PIX_PER_IMAGE(PPI),
    .ADDR_W       (AW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .rom_addr       (rom_addr),
    .rom_rd         (rom_rd),
    .rom_rdata      (rom_rdata),
    .busy           (busy),
    .pix_valid      (pix_valid),
    .pixel_in       (pixel_in),
    .image_in_index (image_in_index),
    .out_valid      (out_valid),
    .color_index    (color_index),
    .image_out_index(image_out_index),
    .res_rd_addr    (res_rd_addr),
    .res_rd_data    (res_rd_data),
    .run_busy       (run_busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: one-cycle read latency, contents equal to the address
  always_ff @(posedge clk) begin
    if (rom_rd) rom_rdata <= 24'(rom_addr);
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pv"},   32'(pix_valid), 0);
    check({tag, "_pix"},  32'(pixel_in), 0);
    check({tag, "_img"},  32'(image_in_index), 0);
    check({tag, "_rd"},   32'(rom_rd), 0);
    check({tag, "_addr"}, 32'(rom_addr), 0);
    check({tag, "_rb"},   32'(run_busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"},  32'(error), 0);
    check({tag, "_rdd"},  32'(res_rd_data), 0);
  endtask

  // Pulse start and check the two-cycle fill latency of the read pipeline
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("st_rb",   32'(run_busy), 1);
    check("st_done", 32'(done), 0);
    check("st_err",  32'(error), 0);
    check("st_rd",   32'(rom_rd), 1);
    check("st_addr", 32'(rom_addr), 0);
    check("st_pv0",  32'(pix_valid), 0);
    @(negedge clk);
    check("st_pv1",  32'(pix_valid), 0);
    check("st_addr1", 32'(rom_addr), 1);
    @(negedge clk);
    exp_pix = 0;
  endtask

  // Consume pixels until exp_pix reaches stop_at; mode 1 applies busy bubbles and a long gap
  task automatic stream(input int mode, input int stop_at);
    int  cyc = 0;
    int  gap = 0;
    bit  gap_done = 1'b0;
    bit  b;
    while ((exp_pix < stop_at) && (cyc < BUDGET)) begin
      check("s_pv",  32'(pix_valid), 1);
      check("s_pix", 32'(pixel_in), 32'(exp_pix));
      check("s_img", 32'(image_in_index), 32'(exp_pix / PPI));
      b = 1'b0;
      if (mode == 1) begin
        if ((exp_pix == 5 * PPI) && !gap_done) begin
          gap = 40;
          gap_done = 1'b1;
        end
        if (gap > 0) begin
          b = 1'b1;
          gap--;
        end else if ((cyc % 3) == 2) begin
          b = 1'b1;
        end
      end
      busy = b;
      if (!b) exp_pix++;
      cyc++;
      @(negedge clk);
    end
    busy = 1'b0;
    if (cyc >= BUDGET) check("s_timeout", 32'(exp_pix), 32'(stop_at));
  endtask

  task automatic end_checks();
    check("e_pv",  32'(pix_valid), 0);
    check("e_rd",  32'(rom_rd), 0);
    check("e_rb",  32'(run_busy), 1);
    check("e_done", 32'(done), 0);
    @(negedge clk);
    check("e_rd2", 32'(rom_rd), 0);
    check("e_pv2", 32'(pix_valid), 0);
  endtask

  task automatic send_result(input logic [1:0] c, input logic [4:0] idx);
    out_valid       = 1'b1;
    color_index     = c;
    image_out_index = idx;
    @(negedge clk);
    out_valid = 1'b0;
  endtask

  task automatic read_res(input logic [4:0] a, input logic [6:0] expv, input string tag);
    res_rd_addr = a;
    @(negedge clk);
    check(tag, 32'(res_rd_data), 32'(expv));
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    busy = 1'b0;
    out_valid = 1'b0;
    color_index = 2'd0;
    image_out_index = 5'd0;
    res_rd_addr = 5'd0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b1;
    @(negedge clk);
    check("idle_rb", 32'(run_busy), 0);
    check("idle_rd", 32'(rom_rd), 0);

    // Run 1: busy held low, well-ordered results
    do_start();
    stream(0, TOTAL);
    end_checks();
    for (int i = 0; i < NIMG; i++) begin
      send_result((i < 11) ? 2'd0 : ((i < 22) ? 2'd1 : 2'd2), 5'(31 - i));
    end
    check("r1_done_early", 32'(done), 0);
    @(negedge clk);
    check("r1_done", 32'(done), 1);
    check("r1_rb",   32'(run_busy), 0);
    check("r1_err",  32'(error), 0);
    read_res(5'd5,  7'd26,   "r1_res5");
    read_res(5'd15, 7'h30,   "r1_res15");
    read_res(5'd31, 7'h40,   "r1_res31");

    // Run 2: busy bubbles plus a long gap; results out of color order
    do_start();
    stream(1, TOTAL);
    end_checks();
    send_result(2'd2, 5'd0);
    check("r2_err_ok", 32'(error), 0);
    send_result(2'd0, 5'd1);
    check("r2_err_order", 32'(error), 1);
    for (int i = 2; i < NIMG; i++) send_result(2'd2, 5'(i));
    check("r2_err_sticky", 32'(error), 1);
    @(negedge clk);
    check("r2_done", 32'(done), 1);
    check("r2_err_done", 32'(error), 1);

    // Run 3: start clears error; a 33rd result is flagged and not stored
    do_start();
    stream(0, TOTAL);
    end_checks();
    for (int i = 0; i < NIMG; i++) send_result(2'd1, 5'(i));
    @(negedge clk);
    check("r3_done", 32'(done), 1);
    check("r3_err",  32'(error), 0);
    send_result(2'd0, 5'd7);
    check("r3_err33", 32'(error), 1);
    read_res(5'd0, 7'h20, "r3_res0");

    // Run 4: color class 3 during streaming, then reset mid image 7
    do_start();
    stream(0, 50);
    busy = 1'b1;
    send_result(2'd3, 5'd0);
    check("r4_err3",  32'(error), 1);
    check("r4_hold_pv",  32'(pix_valid), 1);
    check("r4_hold_pix", 32'(pixel_in), 50);
    busy = 1'b0;
    stream(0, 7 * PPI + 5);
    reset = 1'b0;
    #1;
    check("mid_rst_pv",  32'(pix_valid), 0);
    check("mid_rst_pix", 32'(pixel_in), 0);
    check("mid_rst_img", 32'(image_in_index), 0);
    check("mid_rst_rd",  32'(rom_rd), 0);
    check("mid_rst_addr", 32'(rom_addr), 0);
    check("mid_rst_rb",  32'(run_busy), 0);
    check("mid_rst_err", 32'(error), 0);
    check("mid_rst_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_pv", 32'(pix_valid), 0);
    check("post_rst_rb", 32'(run_busy), 0);
    do_start();
    stream(0, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
